// File: rtl/gsu_go_irq_ctrl_pkg.sv
// Shared types and constants for the GSU run controller.
package gsu_go_irq_ctrl_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned SFR_W       = 16;
  localparam int unsigned SFR_GO_BIT  = 5;
  localparam int unsigned SFR_IRQ_BIT = 15;

  // Controller states; encoding 3 is unused and recovers to IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Places the GO and IRQ flags at their positions in the SFR status word.
  function automatic logic [SFR_W-1:0] sfr_flags(input logic go, input logic irq);
    logic [SFR_W-1:0] w;
    w              = '0;
    w[SFR_GO_BIT]  = go;
    w[SFR_IRQ_BIT] = irq;
    return w;
  endfunction

endpackage

// File: rtl/gsu_go_irq_ctrl_sync_sr_flag.sv
// Clocked set/clear flag; SET_WINS picks which request dominates when both fire.
module gsu_go_irq_ctrl_sync_sr_flag
  import gsu_go_irq_ctrl_pkg::*;
#(
  parameter bit SET_WINS = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  // Flag register with configurable set/clear priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (set && (SET_WINS || !clr)) begin
      q <= 1'b1;
    end else if (clr) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/gsu_go_irq_ctrl.sv
// GSU run controller: sequences start/run/drain/stop and owns the GO and IRQ flags.
module gsu_go_irq_ctrl
  import gsu_go_irq_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               snes_go_wr,
  input  logic               snes_go_data,
  input  logic               snes_sfr_rd,
  input  logic               core_stop,
  input  logic               core_busy,
  input  logic               irq_mask,
  output logic               go,
  output logic               irq_flag,
  output logic               core_run,
  output logic               core_flush,
  output logic               irq_n,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             run_d, flush_d;
  logic             go_set, go_clr, irq_set;

  // State, drain counter, abort flag and core-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      core_run   <= 1'b0;
      core_flush <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      core_run   <= run_d;
      core_flush <= flush_d;
    end
  end

  // Next-state, flag requests and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    run_d   = 1'b0;
    flush_d = 1'b0;
    go_set  = 1'b0;
    go_clr  = 1'b0;
    irq_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (snes_go_wr && snes_go_data) begin
          state_d = ST_RUN;
          go_set  = 1'b1;
          run_d   = 1'b1;
        end
      end
      ST_RUN: begin
        run_d = 1'b1;
        // A GO=0 write dominates a simultaneous STOP and marks the drain as aborted.
        if ((snes_go_wr && !snes_go_data) || core_stop) begin
          state_d = ST_DRAIN;
          abort_d = snes_go_wr && !snes_go_data;
          cnt_d   = CNT_LOAD;
          run_d   = 1'b0;
          flush_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if ((cnt_q == '0) && !core_busy) begin
          state_d = ST_IDLE;
          go_clr  = 1'b1;
          irq_set = !abort_q;
          abort_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // GO flag: cleared only by drain exit, which never coincides with a start.
  gsu_go_irq_ctrl_sync_sr_flag #(.SET_WINS(1'b0)) u_go_flag (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (go_set),
    .clr   (go_clr),
    .q     (go)
  );

  // IRQ flag: a read racing the set sampled the old value, so set wins.
  gsu_go_irq_ctrl_sync_sr_flag #(.SET_WINS(1'b1)) u_irq_flag (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (irq_set),
    .clr   (snes_sfr_rd),
    .q     (irq_flag)
  );

  // Mask gates only the line to the SNES, never the pending flag.
  assign irq_n     = ~(irq_flag & ~irq_mask);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_gsu_go_irq_ctrl.sv
// Directed bench for the GSU run controller with an expectation queue.
module tb_gsu_go_irq_ctrl;

  typedef struct {
    string      tag;
    logic [6:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic snes_go_wr, snes_go_data, snes_sfr_rd, core_stop, core_busy, irq_mask;

  logic       go0, irq0, run0, fl0, irqn0;
  logic [1:0] st0;
  logic       go1, irq1, run1, fl1, irqn1;
  logic [1:0] st1;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gsu_go_irq_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .snes_go_wr   (snes_go_wr),
    .snes_go_data (snes_go_data),
    .snes_sfr_rd  (snes_sfr_rd),
    .core_stop    (core_stop),
    .core_busy    (core_busy),
    .irq_mask     (irq_mask),
    .go           (go0),
    .irq_flag     (irq0),
    .core_run     (run0),
    .core_flush   (fl0),
    .irq_n        (irqn0),
    .state_dbg    (st0)
  );

  gsu_go_irq_ctrl #(.DRAIN_CYCLES(1)) u_dut_min (
    .clk          (clk),
    .rst_n        (rst_n),
    .snes_go_wr   (snes_go_wr),
    .snes_go_data (snes_go_data),
    .snes_sfr_rd  (snes_sfr_rd),
    .core_stop    (core_stop),
    .core_busy    (core_busy),
    .irq_mask     (irq_mask),
    .go           (go1),
    .irq_flag     (irq1),
    .core_run     (run1),
    .core_flush   (fl1),
    .irq_n        (irqn1),
    .state_dbg    (st1)
  );

  wire logic [6:0] obs0 = {st0, go0, irq0, run0, fl0, irqn0};
  wire logic [6:0] obs1 = {st1, go1, irq1, run1, fl1, irqn1};

  // Packs an expected output vector {state, go, irq_flag, core_run, core_flush, irq_n}.
  function automatic logic [6:0] ex(input logic [1:0] st, input logic g, input logic irq,
                                    input logic run, input logic fl, input logic irqn);
    return {st, g, irq, run, fl, irqn};
  endfunction

  task automatic push(input string tag, input logic [6:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [6:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %b with no expectation queued", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
      end
    end
  endtask

  // Queue an expectation, clock once, drop strobes and compare the main DUT.
  task automatic tick(input string tag, input logic [6:0] val);
    push(tag, val);
    @(posedge clk);
    #1;
    snes_go_wr   = 1'b0;
    snes_go_data = 1'b0;
    snes_sfr_rd  = 1'b0;
    core_stop    = 1'b0;
    pop_cmp(obs0);
  endtask

  task automatic now0(input string tag, input logic [6:0] val);
    push(tag, val);
    pop_cmp(obs0);
  endtask

  task automatic now1(input string tag, input logic [6:0] val);
    push(tag, val);
    pop_cmp(obs1);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected sequence end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    snes_go_wr   = 1'b0;
    snes_go_data = 1'b0;
    snes_sfr_rd  = 1'b0;
    core_stop    = 1'b0;
    core_busy    = 1'b0;
    irq_mask     = 1'b0;

    #12;
    now0("rst_init", ex(2'd0, 0, 0, 0, 0, 1));
    now1("rst_init_min", ex(2'd0, 0, 0, 0, 0, 1));
    release_rst();
    tick("idle_hold", ex(2'd0, 0, 0, 0, 0, 1));
    core_stop = 1'b1;
    tick("stop_in_idle", ex(2'd0, 0, 0, 0, 0, 1));
    snes_go_wr = 1'b1; snes_go_data = 1'b0;
    tick("go0_in_idle", ex(2'd0, 0, 0, 0, 0, 1));

    // Start, run, stop, drain with IRQ; the DRAIN_CYCLES=1 instance shadows it.
    snes_go_wr = 1'b1; snes_go_data = 1'b1;
    tick("t1_start", ex(2'd1, 1, 0, 1, 0, 1));
    now1("t6_start", ex(2'd1, 1, 0, 1, 0, 1));
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin snes_go_wr = 1'b1; snes_go_data = 1'b1; end
      tick("t1_run", ex(2'd1, 1, 0, 1, 0, 1));
    end
    core_stop = 1'b1;
    tick("t1_flush", ex(2'd2, 1, 0, 0, 1, 1));
    now1("t6_flush", ex(2'd2, 1, 0, 0, 1, 1));
    tick("t1_drain_a", ex(2'd2, 1, 0, 0, 0, 1));
    now1("t6_go_clear", ex(2'd0, 0, 1, 0, 0, 0));
    tick("t1_drain_b", ex(2'd2, 1, 0, 0, 0, 1));
    tick("t1_done", ex(2'd0, 0, 1, 0, 0, 0));

    // Mask hides the pending IRQ; unmask asserts the line without a clock.
    #1 irq_mask = 1'b1;
    #1 now0("t4_mask_hold", ex(2'd0, 0, 1, 0, 0, 1));
    tick("t4_mask_clk", ex(2'd0, 0, 1, 0, 0, 1));
    irq_mask = 1'b0;
    #1 now0("t4_unmask", ex(2'd0, 0, 1, 0, 0, 0));
    snes_sfr_rd = 1'b1;
    tick("t4_rd_clear", ex(2'd0, 0, 0, 0, 0, 1));

    // Abort: GO=0 write together with STOP.
    snes_go_wr = 1'b1; snes_go_data = 1'b1;
    tick("t2_start", ex(2'd1, 1, 0, 1, 0, 1));
    tick("t2_run", ex(2'd1, 1, 0, 1, 0, 1));
    snes_go_wr = 1'b1; snes_go_data = 1'b0; core_stop = 1'b1;
    tick("t2_abort", ex(2'd2, 1, 0, 0, 1, 1));
    tick("t2_drain_a", ex(2'd2, 1, 0, 0, 0, 1));
    tick("t2_drain_b", ex(2'd2, 1, 0, 0, 0, 1));
    tick("t2_done", ex(2'd0, 0, 0, 0, 0, 1));
    tick("t2_idle", ex(2'd0, 0, 0, 0, 0, 1));

    // Busy stall with ignored GO writes, then exit racing an SFR read.
    snes_go_wr = 1'b1; snes_go_data = 1'b1;
    tick("t3_start", ex(2'd1, 1, 0, 1, 0, 1));
    core_stop = 1'b1; core_busy = 1'b1;
    tick("t3_flush", ex(2'd2, 1, 0, 0, 1, 1));
    for (int i = 0; i < 20; i++) begin
      if (i == 5)  begin snes_go_wr = 1'b1; snes_go_data = 1'b1; end
      if (i == 10) begin snes_go_wr = 1'b1; snes_go_data = 1'b0; end
      tick("t3_stall", ex(2'd2, 1, 0, 0, 0, 1));
    end
    core_busy = 1'b0; snes_sfr_rd = 1'b1;
    tick("t3_exit_race", ex(2'd0, 0, 1, 0, 0, 0));

    // Reset in DRAIN with IRQ pending, then in RUN.
    snes_go_wr = 1'b1; snes_go_data = 1'b1;
    tick("t5_start", ex(2'd1, 1, 1, 1, 0, 0));
    core_stop = 1'b1;
    tick("t5_flush", ex(2'd2, 1, 1, 0, 1, 0));
    #2 rst_n = 1'b0;
    #1 now0("t5_rst_drain", ex(2'd0, 0, 0, 0, 0, 1));
    now1("t5_rst_drain_min", ex(2'd0, 0, 0, 0, 0, 1));
    release_rst();
    tick("t5_idle_after_drain", ex(2'd0, 0, 0, 0, 0, 1));
    snes_go_wr = 1'b1; snes_go_data = 1'b1;
    tick("t5_restart", ex(2'd1, 1, 0, 1, 0, 1));
    #2 rst_n = 1'b0;
    #1 now0("t5_rst_run", ex(2'd0, 0, 0, 0, 0, 1));
    release_rst();
    tick("t5_idle_after_run", ex(2'd0, 0, 0, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
